// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive path.
//   rx_state_t      : receiver FSM states
//   RX_ERR_*        : bit positions inside the Rx_Error flag vector
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int RX_ERR_PARITY  = 0;
    localparam int RX_ERR_FRAME   = 1;
    localparam int RX_ERR_OVERRUN = 2;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Oversampling tick generator, shared by the UART receiver and transmitter.
//   Produces a one-clock Tick every SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE) clocks.
//   Ports:
//     SysClk  in   system clock, rising edge
//     Rst     in   asynchronous active-high reset
//     Clr     in   hold the divider at zero (no ticks while high)
//     Tick    out  oversample tick pulse
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic SysClk,
    input  logic Rst,
    input  logic Clr,
    output logic Tick
);

    localparam int TICK_DIV = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

    // A clock too slow for the requested baud rate cannot be rescued at run time.
    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $fatal(1, "uart_baud_tick: SYSCLK_RATE too low for BAUD_RATE*OVERSAMPLE");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (Clr || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Suppressed while cleared so the first tick after release lands a full
    // divider period (or the very next clock when TICK_DIV==1) later.
    assign Tick = !Clr && (cnt == CNT_LAST);

endmodule : uart_baud_tick

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//   UART receive deframer: synchronises Rx, finds start bits with oversampling,
//   samples each bit at mid-point, checks even parity and stop bits, and hands
//   the word over with a Data_Rdy/Data_Ack handshake plus per-frame error flags.
//   Ports:
//     SysClk    in   system clock, rising edge
//     Rst       in   asynchronous active-high reset
//     Rx        in   serial line, asynchronous, idle high
//     Data_Ack  in   consumer has taken Rx_Data (one-cycle pulse)
//     Rx_Data   out  last delivered word
//     Data_Rdy  out  Rx_Data valid, held until Data_Ack
//     Rx_Error  out  [0] parity, [1] framing, [2] overrun
//     Rx_Busy   out  frame in progress
// -----------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Data_Ack,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = 4;
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] STOP_LAST = BCNT_W'(STOP_BITS - 1);

    rx_state_t             state;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  tick;
    logic [SCNT_W-1:0]     scnt;
    logic [BCNT_W-1:0]     bcnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr;
    logic                  ferr;
    logic                  done;

    // NOTE: the synchroniser resets to the idle-high line level; resetting it
    // to 0 would look like a start bit the moment reset is released.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    // The divider is held at zero in IDLE so bit timing is anchored to the
    // detected falling edge.
    uart_baud_tick #(
        .SYSCLK_RATE (SYSCLK_RATE),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_baud_tick (
        .SysClk (SysClk),
        .Rst    (Rst),
        .Clr    (state == IDLE),
        .Tick   (tick)
    );

    // Frame FSM. scnt counts ticks within a bit, bcnt counts bits within a
    // field. done is a one-cycle flag marking the completion cycle.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    scnt <= '0;
                    bcnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (tick) begin
                    if (scnt == HALF_LAST) begin
                        // Mid-point of the start bit: a high line was a glitch.
                        scnt  <= '0;
                        bcnt  <= '0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (scnt == FULL_LAST) begin
                        scnt  <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};   // LSB arrives first
                        if (bcnt == DATA_LAST) begin
                            bcnt  <= '0;
                            state <= (PARITY_BIT != 0) ? PARITY : STOP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    if (scnt == FULL_LAST) begin
                        scnt  <= '0;
                        perr  <= (rx_s != ^shreg);
                        state <= STOP;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (scnt == FULL_LAST) begin
                        scnt <= '0;
                        if (!rx_s) ferr <= 1'b1;
                        if (bcnt == STOP_LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output handshake. shreg/perr/ferr are stable during the completion cycle
    // because a new frame cannot reach DATA that quickly.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            Rx_Data  <= '0;
            Data_Rdy <= 1'b0;
            Rx_Error <= '0;
        end else if (done) begin
            if (!Data_Rdy || Data_Ack) begin
                Rx_Data                 <= shreg;
                Data_Rdy                <= 1'b1;
                Rx_Error                <= '0;
                Rx_Error[RX_ERR_FRAME]  <= ferr;
                Rx_Error[RX_ERR_PARITY] <= perr;
            end else begin
                // Consumer still holds the previous word: drop the new one.
                Rx_Error[RX_ERR_OVERRUN] <= 1'b1;
            end
        end else if (Data_Ack && Data_Rdy) begin
            Data_Rdy <= 1'b0;
            Rx_Error <= '0;
        end
    end

    assign Rx_Busy = (state != IDLE);

endmodule : uart_rx_deframer

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//   Directed 8E2 frames at 16 clocks per bit. Expected words are queued when a
//   frame is sent; a monitor pops and compares whenever the DUT presents a new
//   word or new flags with Data_Rdy high.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int BIT_CLKS = 16;

    logic       SysClk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx = 1'b1;
    logic       Data_Ack = 1'b0;
    logic [7:0] Rx_Data;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;

    always #5 SysClk = ~SysClk;

    uart_rx_deframer #(
        .SYSCLK_RATE (153600),
        .BAUD_RATE   (9600),
        .DATA_BITS   (8),
        .PARITY_BIT  (1),
        .STOP_BITS   (2),
        .OVERSAMPLE  (16)
    ) dut (
        .SysClk   (SysClk),
        .Rst      (Rst),
        .Rx       (Rx),
        .Data_Ack (Data_Ack),
        .Rx_Data  (Rx_Data),
        .Data_Rdy (Data_Rdy),
        .Rx_Error (Rx_Error),
        .Rx_Busy  (Rx_Busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_cycle;
    logic mid_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a presentation is Data_Rdy rising, or word/flags changing while high.
    logic       prev_rdy  = 1'b0;
    logic [7:0] prev_data = '0;
    logic [2:0] prev_err  = '0;
    always @(negedge SysClk) begin
        if (!Rst && Data_Rdy &&
            (!prev_rdy || Rx_Data !== prev_data || Rx_Error !== prev_err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_delivery: got data 0x%0h err %b, expected none",
                         Rx_Data, Rx_Error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", Rx_Data, e.data);
                check("rx_error", Rx_Error, e.err);
            end
        end
        prev_rdy  = Data_Rdy;
        prev_data = Rx_Data;
        prev_err  = Rx_Error;
    end

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge SysClk);
    endtask

    // Sends start, 8 data bits LSB first, parity, two stops; cycle 1 is the
    // first negedge after the start bit begins. ack_at pulses Data_Ack there.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic s1,
                              input logic s2, input int ack_at,
                              output int rdy_cyc, output logic busy_mid);
        logic [11:0] f;
        int          cyc;
        logic        prev;
        f        = {s2, s1, par, data, 1'b0};
        cyc      = 0;
        rdy_cyc  = -1;
        busy_mid = 1'b0;
        prev     = Data_Rdy;
        for (int b = 0; b < 12; b++) begin
            Rx = f[b];
            for (int k = 0; k < BIT_CLKS; k++) begin
                @(negedge SysClk);
                cyc++;
                Data_Ack = (cyc == ack_at);
                if (Data_Rdy && !prev && rdy_cyc < 0) rdy_cyc = cyc;
                prev = Data_Rdy;
                if (cyc == 100) busy_mid = Rx_Busy;
            end
        end
        Data_Ack = 1'b0;
        idle(32);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge SysClk);
            t++;
        end
        check({"drain ", name}, sb.size(), 0);
    endtask

    task automatic ack(input string name);
        @(negedge SysClk);
        Data_Ack = 1'b1;
        @(negedge SysClk);
        Data_Ack = 1'b0;
        check({name, " rdy after ack"}, Data_Rdy, 0);
        check({name, " err after ack"}, Rx_Error, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values, during and after reset (no false start on release).
        repeat (3) @(negedge SysClk);
        check("reset rx_data", Rx_Data, 0);
        check("reset data_rdy", Data_Rdy, 0);
        check("reset rx_error", Rx_Error, 0);
        check("reset rx_busy", Rx_Busy, 0);
        Rst = 1'b0;
        idle(8);
        check("post-reset data_rdy", Data_Rdy, 0);
        check("post-reset rx_busy", Rx_Busy, 0);

        // 1: clean 0xAA; Data_Rdy must rise within the second stop bit.
        sb.push_back('{data: 8'hAA, err: 3'b000});
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        check("t1 busy mid-frame", mid_busy, 1);
        check("t1 rdy in stop2", (rdy_cycle >= 178 && rdy_cycle <= 192), 1);
        drain("t1");
        ack("t1");

        // 2: 0x55 has even ones, parity bit 1 is wrong.
        sb.push_back('{data: 8'h55, err: 3'b001});
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        drain("t2");
        ack("t2");

        // 3: 0x3C with second stop bit low.
        sb.push_back('{data: 8'h3C, err: 3'b010});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, rdy_cycle, mid_busy);
        drain("t3");
        ack("t3");

        // 4: 4-clock glitch is a false start.
        Rx = 1'b0;
        repeat (4) @(negedge SysClk);
        check("t4 busy on glitch", Rx_Busy, 1);
        idle(12);
        check("t4 busy dropped", Rx_Busy, 0);
        check("t4 no delivery", Data_Rdy, 0);
        idle(16);

        // 5a: two frames without ack -> first word kept, overrun flagged.
        sb.push_back('{data: 8'h11, err: 3'b000});
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        sb.push_back('{data: 8'h11, err: 3'b100});
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        drain("t5a");
        ack("t5a");

        // 5b: ack lands in the completion cycle of 0x22 -> 0x22 replaces 0x11.
        sb.push_back('{data: 8'h11, err: 3'b000});
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        sb.push_back('{data: 8'h22, err: 3'b000});
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 187, rdy_cycle, mid_busy);
        drain("t5b");
        check("t5b rdy held", Data_Rdy, 1);

        // 6: reset in the middle of 0x99 (start + 3 data bits), then clean 0x0F.
        Rx = 1'b0;
        repeat (BIT_CLKS) @(negedge SysClk);
        Rx = 1'b1;
        repeat (BIT_CLKS) @(negedge SysClk);
        Rx = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge SysClk);
        check("t6 busy before reset", Rx_Busy, 1);
        #2 Rst = 1'b1;
        #1;
        check("t6 reset rx_data", Rx_Data, 0);
        check("t6 reset data_rdy", Data_Rdy, 0);
        check("t6 reset rx_error", Rx_Error, 0);
        check("t6 reset rx_busy", Rx_Busy, 0);
        @(negedge SysClk);
        Rx = 1'b1;
        repeat (2) @(negedge SysClk);
        Rst = 1'b0;
        idle(40);
        sb.push_back('{data: 8'h0F, err: 3'b000});
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 0, rdy_cycle, mid_busy);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_deframer
